cm_arbiter: RTL and testbench
=============================

# cm_arbiter

Round-robin arbiter and sequencer that shares one complex multiplier (CM) between `N_REQ` requesters, typically several MAC controllers.
- Accepts one request at a time and registers the winner's operands into the CM.
- Runs the CM start/ready handshake.
- Returns the product to the winner with a one-cycle valid pulse.
- Sits between the MAC controllers and the single CM instance in the datapath.

## Interface
- `N_REQ`, default 2: number of requesters (2..8).
- `WIDTH`, default 16: width of one real or imaginary component of an operand.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `req`  in  N_REQ: request level per requester.
- `req_a`  in  N_REQ*2*WIDTH: operand A per requester. Slot i occupies bits [i*2W +: 2W]; real part in the upper half.
- `req_b`  in  N_REQ*2*WIDTH: operand B, same packing as `req_a`.
- `grant`  out  N_REQ: one-hot, one-cycle pulse marking the accepted requester.
- `rsp_valid`  out  N_REQ: one-hot, one-cycle pulse that qualifies `rsp_data`.
- `rsp_data`  out  4*WIDTH: product, real part in the upper 2*WIDTH bits. Held until the next response.
- `busy`  out  1: high in every state except IDLE.
- `cm_start`  out  1: one-cycle start pulse to the CM.
- `cm_a`, `cm_b`  out  2*WIDTH each: registered operands to the CM.
- `cm_ready`  in  1: CM idle/done. Drops the cycle after `cm_start` and rises when the product is valid.
- `cm_p`  in  4*WIDTH: CM product, valid while `cm_ready` is high.

## Operation
- **FSM states:** IDLE, START, WAIT, RESP.
- **IDLE:** when `req` != 0, select winner w, capture `req_a[w]`/`req_b[w]` into `cm_a`/`cm_b`, go to START. When `req` == 0, stay in IDLE.
- **START:** drive `grant[w]`=1 and `cm_start`=1, go to WAIT.
- **WAIT:** hold while `cm_ready`=0. When `cm_ready`=1, capture `cm_p` into `rsp_data` and go to RESP.
- **RESP:** drive `rsp_valid[w]`=1 and go to IDLE.
- **Request sampling:** `req` is sampled only in IDLE. Requests raised in other states wait.
  - A requester that keeps `req` high after its `rsp_valid` makes a new request.
  - A requester must hold its `req` and operands stable until its `grant`.
- **Round-robin:** pointer `last` holds the index of the last winner. The search starts at `last`+1 mod N_REQ and wraps. `last` is updated on entry to START.
- **Data path:** operands and the product pass through unmodified, with no arithmetic in this block.
- **Reset values:** all outputs 0, `cm_a`/`cm_b`/`rsp_data` = 0, state IDLE, `last` = N_REQ-1, so requester 0 wins first.

## Timing
- **Request to start:** `req` seen in IDLE at cycle t gives `grant` and `cm_start` at t+1.
- **Ready to response:** `cm_ready` first seen high in WAIT at cycle u gives `rsp_valid` and new `rsp_data` at u+1. With CM latency L cycles after start, u = t+1+L.
- **Throughput:** minimum op period is L+3 cycles. There is no overlap of operations.
- **Ready semantics:** `cm_ready` high in the START cycle is ignored. Only WAIT samples it.
- **Simultaneous requests:** exactly one grant per op. The others are served in rotation order on later IDLE visits. No requester waits more than N_REQ-1 ops.
- **Reset mid-op:** an asynchronous `rst` low returns to IDLE immediately. `cm_start`, `grant` and `rsp_valid` drop immediately. The in-flight result is discarded and no `rsp_valid` is issued.
- **Unknown requests:** bits of `req` at index >= N_REQ do not exist. X on an unselected slot has no effect.

## Configuration
- **`CM_ARB_FIXED_PRIO_EN` defined:** fixed priority, lowest asserted index wins. `last` is removed and never updated.
- **`CM_ARB_FIXED_PRIO_EN` undefined (default):** round-robin as above.
- **Invariant:** FSM and timing are identical in both modes.

## Structure
- **Package `cm_arb_pkg`:**
  - state encoding: IDLE=2'b00, START=2'b01, WAIT=2'b10, RESP=2'b11;
  - the `N_REQ` upper bound;
  - the operand/product width helper constants (2*WIDTH, 4*WIDTH).
- **Sub-module `cm_arb_rr_pick`:** combinational rotating-base priority encoder. Inputs are `req` and base; outputs are the one-hot winner and its index. In fixed-priority mode it is instantiated with base tied to 0.
- **Top level:** holds the FSM, the winner/`last` registers, the operand mux with its capture registers, and the response register.

## Test plan
All scenarios use N_REQ=2, WIDTH=8, and a CM model with latency L=2 unless noted.
1. **Reset:** `rst`=0 then released -> all outputs 0 and `busy`=0.
   - Then `req`=2'b01, `req_a[0]`=16'h0302, `req_b[0]`=16'h0104 -> `grant`=01 and `cm_start` at t+1; `cm_a`=16'h0302, `cm_b`=16'h0104; `rsp_valid`=01 at t+4 with `rsp_data`=`cm_p`.
2. **Simultaneous requests:** `req`=2'b11 held -> grants in the order 01, 10, 01, 10. Each `rsp_valid` matches its grant, and operands come from the matching slot.
3. **Fixed priority:** with `CM_ARB_FIXED_PRIO_EN`, `req`=2'b11 held -> every grant is 01.
4. **Slow CM:** CM holds `cm_ready`=0 for 10 cycles -> state stays WAIT and `busy`=1. `rsp_valid` follows 1 cycle after ready rises. A `req[1]` raised during WAIT is granted only after return to IDLE.
5. **Reset mid-op:** `rst` low during WAIT -> `busy`/`cm_start`/`grant` go 0 immediately and no `rsp_valid` is issued. After release, `req`=2'b11 -> first grant 01.
6. **Ready during START:** `cm_ready` stuck high through START -> ignored in START. `rsp_valid` is issued at START+2 (WAIT samples ready on its first cycle).

Source files
------------

// File: rtl/cm_arb_pkg.sv
// cm_arb_pkg: shared state encoding, requester bound and width helpers for cm_arbiter.
package cm_arb_pkg;
    localparam int N_REQ_MAX = 8;
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_t;
    function automatic int op_w(int w);
        return 2 * w;
    endfunction
    function automatic int prod_w(int w);
        return 4 * w;
    endfunction
    function automatic int idx_w(int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/cm_arbiter_if.sv
// cm_arbiter_if: requester-side and CM-side signals of cm_arbiter.
// slave is the arbiter's view; master is the requesters plus the CM.
interface cm_arbiter_if
    import cm_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int WIDTH = 16
) ();
    logic [N_REQ-1:0]                 req;
    logic [N_REQ*op_w(WIDTH)-1:0]     req_a;
    logic [N_REQ*op_w(WIDTH)-1:0]     req_b;
    logic [N_REQ-1:0]                 grant;
    logic [N_REQ-1:0]                 rsp_valid;
    logic [prod_w(WIDTH)-1:0]         rsp_data;
    logic                             busy;
    logic                             cm_start;
    logic [op_w(WIDTH)-1:0]           cm_a;
    logic [op_w(WIDTH)-1:0]           cm_b;
    logic                             cm_ready;
    logic [prod_w(WIDTH)-1:0]         cm_p;
    modport slave (
        input  req, req_a, req_b, cm_ready, cm_p,
        output grant, rsp_valid, rsp_data, busy, cm_start, cm_a, cm_b
    );
    modport master (
        output req, req_a, req_b, cm_ready, cm_p,
        input  grant, rsp_valid, rsp_data, busy, cm_start, cm_a, cm_b
    );
endinterface

// File: rtl/cm_arb_rr_pick.sv
// cm_arb_rr_pick: rotating-base priority encoder; the first set req at or after base wins.
module cm_arb_rr_pick
    import cm_arb_pkg::*;
#(
    parameter  int N_REQ = 2,
    localparam int IW    = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    base,
    output logic [N_REQ-1:0] onehot,
    output logic [IW-1:0]    idx
);
    logic [2*N_REQ-1:0] rot;
    assign rot = {req, req} >> base;
    always_comb begin
        idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (rot[k]) idx = IW'((int'(base) + k) % N_REQ);
    end
    assign onehot = (|req) ? N_REQ'(1) << idx : '0;
endmodule

// File: rtl/cm_arbiter.sv
// cm_arbiter: shares one complex multiplier between N_REQ requesters (round-robin).
// Define CM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); N_REQ/WIDTH must match bus.
module cm_arbiter
    import cm_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int WIDTH = 16
) (
    input logic         clk,
    input logic         rst,
    cm_arbiter_if.slave bus
);
    localparam int OPW = op_w(WIDTH);
    localparam int IW  = idx_w(N_REQ);

    if (N_REQ < 2 || N_REQ > N_REQ_MAX) begin : g_bad_n_req
        $error("cm_arbiter: N_REQ out of range");
    end

    state_t           state;
    logic [N_REQ-1:0] win;
    logic [N_REQ-1:0] pick_oh;
    logic [IW-1:0]    pick_idx;
    logic [IW-1:0]    base;
    logic [OPW-1:0]   sel_a;
    logic [OPW-1:0]   sel_b;

`ifdef CM_ARB_FIXED_PRIO_EN
    assign base = '0;
`else
    logic [IW-1:0] last;
    assign base = (last == IW'(N_REQ - 1)) ? '0 : last + 1'b1;
`endif

    cm_arb_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (bus.req),
        .base   (base),
        .onehot (pick_oh),
        .idx    (pick_idx)
    );

    assign sel_a    = bus.req_a[pick_idx*OPW +: OPW];
    assign sel_b    = bus.req_b[pick_idx*OPW +: OPW];
    assign bus.busy = state != IDLE;

    // grant/cm_start/rsp_valid are one-cycle pulses, cleared every cycle unless re-armed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            win           <= '0;
            bus.grant     <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_data  <= '0;
            bus.cm_start  <= 1'b0;
            bus.cm_a      <= '0;
            bus.cm_b      <= '0;
`ifndef CM_ARB_FIXED_PRIO_EN
            last          <= IW'(N_REQ - 1);
`endif
        end else begin
            bus.grant     <= '0;
            bus.cm_start  <= 1'b0;
            bus.rsp_valid <= '0;
            case (state)
                IDLE: if (|bus.req) begin
                    state        <= START;
                    win          <= pick_oh;
                    bus.grant    <= pick_oh;
                    bus.cm_start <= 1'b1;
                    bus.cm_a     <= sel_a;
                    bus.cm_b     <= sel_b;
`ifndef CM_ARB_FIXED_PRIO_EN
                    last         <= pick_idx;
`endif
                end
                START: state <= WAIT;
                WAIT: if (bus.cm_ready) begin
                    bus.rsp_data  <= bus.cm_p;
                    bus.rsp_valid <= win;
                    state         <= RESP;
                end
                RESP: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cm_arbiter.sv
// tb_cm_arbiter: scoreboard bench for cm_arbiter with N_REQ=2, WIDTH=8 and a latency-L CM model.
module tb_cm_arbiter;
    typedef struct {
        logic [1:0]  oh;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
        int          g;
        int          r;
    } op_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   lat = 2;
    bit   stuck = 1'b0;
    int   cnt = 0;
    logic rdy = 1'b1;
    logic [15:0] sa [2];
    logic [15:0] sb [2];
    logic [31:0] sp [2];
    op_t  gq [$];
    op_t  rq [$];
    op_t  mg;
    op_t  mr;
    int   c;

    cm_arbiter_if #(.N_REQ(2), .WIDTH(8)) bus ();
    cm_arbiter #(.N_REQ(2), .WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // CM model: complex multiply, ready low for lat-1 cycles after a start
    logic signed [7:0]  ar, ai, br, bi;
    logic signed [15:0] pr, pim;
    assign ar = bus.cm_a[15:8];
    assign ai = bus.cm_a[7:0];
    assign br = bus.cm_b[15:8];
    assign bi = bus.cm_b[7:0];
    assign pr  = ar * br - ai * bi;
    assign pim = ar * bi + ai * br;
    assign bus.cm_p     = {pr, pim};
    assign bus.cm_ready = rdy | stuck;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= 0;
            rdy <= 1'b1;
        end else if (bus.cm_start) begin
            cnt <= lat - 1;
            rdy <= 1'b0;
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
            rdy <= (cnt == 1);
        end
    end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(int s, int g, bit rsp);
        op_t e;
        e.oh = 2'(1 << s);
        e.a  = sa[s];
        e.b  = sb[s];
        e.p  = sp[s];
        e.g  = g;
        e.r  = stuck ? g + 2 : g + lat + 1;
        gq.push_back(e);
        if (rsp) rq.push_back(e);
    endtask

    task automatic set_slots();
        bus.req_a = {sa[1], sa[0]};
        bus.req_b = {sb[1], sb[0]};
    endtask

    task automatic drain();
        int n = 0;
        while ((gq.size() + rq.size()) != 0 && n < 300) begin
            tick(1);
            n++;
        end
        chk("drain_pending", 64'(gq.size() + rq.size()), 64'(0));
        tick(1);
    endtask

    task automatic do_reset();
        bus.req = 2'b00;
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
    endtask

    function automatic int exp_slot(int k);
`ifdef CM_ARB_FIXED_PRIO_EN
        return 0;
`else
        return k % 2;
`endif
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (bus.grant != 2'b00) begin
                if (gq.size() == 0) chk("unexpected_grant", 64'(bus.grant), 64'(0));
                else begin
                    mg = gq.pop_front();
                    chk("grant", 64'(bus.grant), 64'(mg.oh));
                    chk("grant_cycle", 64'(cyc), 64'(mg.g));
                    chk("cm_start", 64'(bus.cm_start), 64'(1));
                    chk("cm_a", 64'(bus.cm_a), 64'(mg.a));
                    chk("cm_b", 64'(bus.cm_b), 64'(mg.b));
                end
            end
            if (bus.rsp_valid != 2'b00) begin
                if (rq.size() == 0) chk("unexpected_rsp", 64'(bus.rsp_valid), 64'(0));
                else begin
                    mr = rq.pop_front();
                    chk("rsp_valid", 64'(bus.rsp_valid), 64'(mr.oh));
                    chk("rsp_cycle", 64'(cyc), 64'(mr.r));
                    chk("rsp_data", 64'(bus.rsp_data), 64'(mr.p));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: no finish within time limit");
        $fatal(1);
    end

    initial begin
        bus.req = 2'b00;
        sa[0] = 16'h0302; sb[0] = 16'h0104; sp[0] = 32'hFFFB000E;
        sa[1] = 16'h0201; sb[1] = 16'h0203; sp[1] = 32'h00010008;
        set_slots();
        tick(3);
        rst = 1'b1;
        tick(1);
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_grant", 64'(bus.grant), 64'(0));
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("rst_cm_start", 64'(bus.cm_start), 64'(0));
        chk("rst_cm_a", 64'(bus.cm_a), 64'(0));
        chk("rst_cm_b", 64'(bus.cm_b), 64'(0));
        chk("rst_rsp_data", 64'(bus.rsp_data), 64'(0));

        // single request, L=2
        bus.req = 2'b01;
        c = cyc;
        push(0, c + 1, 1'b1);
        tick(1);
        bus.req = 2'b00;
        drain();
        chk("rsp_hold", 64'(bus.rsp_data), 64'(sp[0]));

        // both requesting continuously
        do_reset();
        bus.req = 2'b11;
        c = cyc;
        for (int k = 0; k < 4; k++) push(exp_slot(k), c + 1 + k * 5, 1'b1);
        tick(16);
        bus.req = 2'b00;
        drain();

        // slow CM, late request from slot 1 waits for IDLE
        lat = 11;
        bus.req = 2'b01;
        c = cyc;
        push(0, c + 1, 1'b1);
        tick(1);
        bus.req = 2'b00;
        tick(4);
        chk("wait_busy", 64'(bus.busy), 64'(1));
        bus.req = 2'b10;
        push(1, c + 15, 1'b1);
        tick(10);
        bus.req = 2'b00;
        drain();

        // reset while in WAIT
        bus.req = 2'b01;
        c = cyc;
        push(0, c + 1, 1'b0);
        tick(4);
        bus.req = 2'b00;
        rst = 1'b0;
        #1;
        chk("midrst_busy", 64'(bus.busy), 64'(0));
        chk("midrst_cm_start", 64'(bus.cm_start), 64'(0));
        chk("midrst_grant", 64'(bus.grant), 64'(0));
        chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("midrst_rsp_data", 64'(bus.rsp_data), 64'(0));
        tick(2);
        rst = 1'b1;
        tick(1);
        lat = 2;
        bus.req = 2'b11;
        c = cyc;
        push(0, c + 1, 1'b1);
        tick(1);
        bus.req = 2'b00;
        drain();

        // ready stuck high through START
        stuck = 1'b1;
        sa[1] = 16'hFE03; sb[1] = 16'h0505; sp[1] = 32'hFFE70005;
        set_slots();
        bus.req = 2'b10;
        c = cyc;
        push(1, c + 1, 1'b1);
        tick(1);
        bus.req = 2'b00;
        drain();
        stuck = 1'b0;

        tick(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
